// File: rtl/pc_fetch_unit.sv
`timescale 1ns/1ps
// PC and instruction-fetch unit: resolves the next PC on updPC and fetches over req/valid.
// Optional feature macro: PC_FETCH_BR_COUNT_EN builds a saturating taken-branch counter.
module pc_fetch_unit #(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               updPC,
    input  logic [2:0]         brOp,
    input  logic [PC_W-1:0]    brOffset,
    input  logic               flagN,
    input  logic               flagZ,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_valid,
    output logic [PC_W-1:0]    pc,
    output logic [5:0]         opcode,
    output logic [4:0]         func,
    output logic               stall,
    output logic               upd_err,
    output logic [15:0]        br_taken_cnt
);

    localparam logic [5:0] OpNop = 6'b100101;

    typedef enum logic [1:0] {StFetch, StWait, StHold} state_e;

    state_e             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    addr_q;
    logic               req_q;
    logic               stall_q;
    logic               upd_err_q;
    logic [INSTR_W-1:0] instr_q;
    logic               taken;
    logic [PC_W-1:0]    pc_next;

    always_comb begin
        taken = 1'b0;
        if (!brOp[2]) begin
            case (brOp[1:0])
                2'b00:   taken = 1'b1;
                2'b01:   taken = flagN;
                2'b10:   taken = !flagN && !flagZ;
                default: taken = flagZ;
            endcase
        end
    end

    // Wrap-around is intentional: the add is simply truncated to PC_W bits.
    assign pc_next = pc_q + PC_W'(1) + (taken ? brOffset : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            req_q     <= 1'b0;
            stall_q   <= 1'b1;
            upd_err_q <= 1'b0;
            instr_q   <= '0;
        end else begin
            if (updPC && state_q != StHold) begin
                upd_err_q <= 1'b1;
            end
            case (state_q)
                StFetch: begin
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                    state_q <= StWait;
                end
                StWait: begin
                    if (imem_valid) begin
                        instr_q <= imem_data;
                        req_q   <= 1'b0;
                        stall_q <= 1'b0;
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (updPC) begin
                        pc_q    <= pc_next;
                        stall_q <= 1'b1;
                        state_q <= StFetch;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign pc        = pc_q;
    assign stall     = stall_q;
    assign upd_err   = upd_err_q;
    assign opcode    = stall_q ? OpNop : instr_q[31:26];
    assign func      = stall_q ? 5'd0 : instr_q[4:0];

    logic unused_instr;
    assign unused_instr = ^instr_q;

`ifdef PC_FETCH_BR_COUNT_EN
    logic [15:0] br_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q <= '0;
        end else if (state_q == StHold && updPC && taken && br_cnt_q != 16'hFFFF) begin
            br_cnt_q <= br_cnt_q + 16'd1;
        end
    end

    assign br_taken_cnt = br_cnt_q;
`else
    assign br_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for pc_fetch_unit: driver pushes expected PCs, monitor checks each fetch.
module tb_pc_fetch_unit;

    localparam logic [5:0] NOP = 6'b100101;

    logic        clk = 1'b0;
    logic        rst;
    logic        updPC;
    logic [2:0]  brOp;
    logic [31:0] brOffset;
    logic        flagN;
    logic        flagZ;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_valid;
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [4:0]  func;
    logic        stall;
    logic        upd_err;
    logic [15:0] br_taken_cnt;

    pc_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .updPC        (updPC),
        .brOp         (brOp),
        .brOffset     (brOffset),
        .flagN        (flagN),
        .flagZ        (flagZ),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .imem_valid   (imem_valid),
        .pc           (pc),
        .opcode       (opcode),
        .func         (func),
        .stall        (stall),
        .upd_err      (upd_err),
        .br_taken_cnt (br_taken_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          mem_delay = 1;
    int          mcnt = 0;
    int          taken_total = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] off;
        logic        n;
        logic        z;
        logic [31:0] exp_pc;
        logic        taken;
    } vec_t;

    vec_t vecs[$];

    // Memory content: opcode = addr[5:0]+1, func = addr[4:0]; address 0 gives 0x0400_0000.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        logic [5:0] o;
        o = a[5:0] + 6'd1;
        return {o, 21'd0, a[4:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: answers mem_delay cycles after it first sees imem_req.
    initial begin
        imem_valid = 1'b0;
        imem_data  = '0;
    end

    always @(posedge clk) begin
        logic [31:0] a;
        if (rst) begin
            mcnt = 0;
            #1 imem_valid = 1'b0;
        end else if (imem_valid) begin
            mcnt = 0;
            #1 imem_valid = 1'b0;
        end else if (imem_req) begin
            if (mcnt >= mem_delay - 1) begin
                a    = imem_addr;
                mcnt = 0;
                #1;
                imem_data  = instr_of(a);
                imem_valid = 1'b1;
            end else begin
                mcnt++;
            end
        end
    end

    // Monitor: every stall 1->0 transition presents one fetched instruction.
    initial begin
        logic        prev_stall;
        logic [31:0] e;
        logic [31:0] w;
        prev_stall = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev_stall && !stall) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_fetch: got pc %h, expected no fetch", pc);
                end else begin
                    e = exp_q.pop_front();
                    w = instr_of(e);
                    check("fetch_pc", pc, e);
                    check("fetch_addr", imem_addr, e);
                    check("fetch_opcode", 32'(opcode), 32'(w[31:26]));
                    check("fetch_func", 32'(func), 32'(w[4:0]));
                end
            end
            prev_stall = stall;
        end
    end

    task automatic wait_hold();
        int i;
        i = 0;
        while ((stall || exp_q.size() != 0) && i < 60) begin
            @(negedge clk);
            i++;
        end
        if (i >= 60) begin
            n_checks++;
            n_fail++;
            $display("FAIL hold_timeout: got stall %b queue %0d, expected HOLD", stall,
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_cnt();
`ifdef PC_FETCH_BR_COUNT_EN
        check("br_taken_cnt", 32'(br_taken_cnt), 32'(taken_total));
`else
        check("br_taken_cnt", 32'(br_taken_cnt), 32'd0);
`endif
    endtask

    task automatic do_upd(input vec_t v);
        int cnt;
        updPC    = 1'b1;
        brOp     = v.op;
        brOffset = v.off;
        flagN    = v.n;
        flagZ    = v.z;
        exp_q.push_back(v.exp_pc);
        if (v.taken) taken_total++;
        @(negedge clk);
        updPC = 1'b0;
        brOp  = 3'b100;
        cnt   = 0;
        while (stall && cnt < 60) begin
            cnt++;
            @(negedge clk);
        end
        check("stall_cycles", 32'(cnt), 32'd3);
        wait_hold();
        check_cnt();
    endtask

    task automatic check_reset_vals();
        check("rst_pc", pc, 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_opcode", 32'(opcode), 32'(NOP));
        check("rst_func", 32'(func), 32'd0);
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_upd_err", 32'(upd_err), 32'd0);
        check("rst_cnt", 32'(br_taken_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        rst      = 1'b1;
        updPC    = 1'b0;
        brOp     = 3'b100;
        brOffset = '0;
        flagN    = 1'b0;
        flagZ    = 1'b0;

        vecs.push_back('{3'b000, 32'd4,          1'b0, 1'b0, 32'd5,  1'b1});
        vecs.push_back('{3'b100, 32'd9,          1'b0, 1'b0, 32'd6,  1'b0});
        vecs.push_back('{3'b000, 32'd3,          1'b0, 1'b0, 32'd10, 1'b1});
        vecs.push_back('{3'b011, 32'hFFFF_FFFC,  1'b0, 1'b1, 32'd7,  1'b1});
        vecs.push_back('{3'b000, 32'd2,          1'b0, 1'b0, 32'd10, 1'b1});
        vecs.push_back('{3'b011, 32'hFFFF_FFFC,  1'b0, 1'b0, 32'd11, 1'b0});
        vecs.push_back('{3'b000, 32'd8,          1'b0, 1'b0, 32'd20, 1'b1});
        vecs.push_back('{3'b010, 32'd5,          1'b0, 1'b0, 32'd26, 1'b1});
        vecs.push_back('{3'b000, 32'hFFFF_FFF9,  1'b0, 1'b0, 32'd20, 1'b1});
        vecs.push_back('{3'b010, 32'd5,          1'b0, 1'b1, 32'd21, 1'b0});
        vecs.push_back('{3'b001, 32'd10,         1'b1, 1'b0, 32'd32, 1'b1});
        vecs.push_back('{3'b001, 32'd10,         1'b0, 1'b0, 32'd33, 1'b0});
        vecs.push_back('{3'b111, 32'd50,         1'b1, 1'b1, 32'd34, 1'b0});
        vecs.push_back('{3'b010, 32'd5,          1'b1, 1'b0, 32'd35, 1'b0});

        @(negedge clk);
        @(negedge clk);
        check_reset_vals();
        exp_q.push_back(32'd0);
        rst = 1'b0;
        wait_hold();

        foreach (vecs[i]) do_upd(vecs[i]);

        // updPC during a slow fetch: ignored, flags upd_err, request stays up.
        mem_delay = 4;
        updPC = 1'b1;
        brOp  = 3'b100;
        exp_q.push_back(32'd36);
        @(negedge clk);
        updPC = 1'b0;
        @(negedge clk);
        check("wait_req_first", 32'(imem_req), 32'd1);
        updPC    = 1'b1;
        brOp     = 3'b000;
        brOffset = 32'd100;
        @(negedge clk);
        updPC = 1'b0;
        brOp  = 3'b100;
        check("upd_err_set", 32'(upd_err), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("wait_req_held", 32'(imem_req), 32'd1);
            check("wait_pc", pc, 32'd36);
            @(negedge clk);
        end
        wait_hold();
        check("upd_err_sticky", 32'(upd_err), 32'd1);
        check_cnt();

        // Reset asserted mid-WAIT takes effect without a clock edge.
        updPC = 1'b1;
        @(negedge clk);
        updPC = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals();
        taken_total = 0;
        mem_delay   = 1;
        @(negedge clk);
        @(negedge clk);
        exp_q.push_back(32'd0);
        rst = 1'b0;
        wait_hold();

        v = '{3'b000, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1};
        do_upd(v);
        v = '{3'b100, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0};
        do_upd(v);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
